ct_ifu_btb_upd_buf: RTL

//  BTB write-update buffer. Receives mispredict BTB updates from the IB-stage address generator
//  (index/tag/20-bit target) and retires them into the BTB array only on cycles when the array
//  has no lookup. Same-index pending updates merge in place. Overflow drops the newest update
//  (BTB content is a hint) and pulses an HPCP event.

---
 rtl/ct_ifu_btb_upd_buf.sv | 112 +++++++++++
 1 files changed

// File: rtl/ct_ifu_btb_upd_buf.sv
// BTB write-update buffer: queues mispredict BTB updates and retires them into the
// BTB array on cycles with no array lookup. Same-index pending updates merge in place.
// On overflow the newest update is dropped and an HPCP event pulses.
module ct_ifu_btb_upd_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned IDX_W = 10,
    parameter int unsigned TAG_W = 10,
    parameter int unsigned TGT_W = 20
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             addrgen_btb_update_vld,
    input  logic [IDX_W-1:0] addrgen_btb_index,
    input  logic [TAG_W-1:0] addrgen_btb_tag,
    input  logic [TGT_W-1:0] addrgen_btb_target_pc,
    input  logic             btb_array_busy,
    input  logic             btb_upd_flush,
    output logic             ubuf_btb_wen,
    output logic [IDX_W-1:0] ubuf_btb_widx,
    output logic [TAG_W-1:0] ubuf_btb_wtag,
    output logic [TGT_W-1:0] ubuf_btb_wtarget,
    output logic             ubuf_empty,
    output logic             ubuf_full,
    output logic             ifu_hpcp_btb_upd_drop
);

    // Pointers carry an extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]   head_ptr_q;
    logic [PTR_W:0]   tail_ptr_q;
    logic [DEPTH-1:0] valid_q;
    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TGT_W-1:0] tgt_q [DEPTH];

    logic [PTR_W-1:0] head_sel;
    logic [PTR_W-1:0] tail_sel;
    logic             pop;
    logic             merge_hit;
    logic [PTR_W-1:0] merge_sel;
    logic             do_merge;
    logic             do_push;

    assign head_sel = head_ptr_q[PTR_W-1:0];
    assign tail_sel = tail_ptr_q[PTR_W-1:0];

    assign ubuf_empty = (head_ptr_q == tail_ptr_q);
    assign ubuf_full  = (head_sel == tail_sel) && (head_ptr_q[PTR_W] != tail_ptr_q[PTR_W]);

    // Head retires whenever the array is free; flush suppresses the write.
    assign pop = !ubuf_empty && !btb_array_busy && !btb_upd_flush;

    assign ubuf_btb_wen     = pop;
    assign ubuf_btb_widx    = idx_q[head_sel];
    assign ubuf_btb_wtag    = tag_q[head_sel];
    assign ubuf_btb_wtarget = tgt_q[head_sel];

    // Find a pending entry with the same index; the head leaving this cycle is excluded
    // so a re-update of the index being written gets queued again instead of lost.
    always_comb begin
        merge_hit = 1'b0;
        merge_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (idx_q[i] == addrgen_btb_index) &&
                !(pop && (PTR_W'(i) == head_sel))) begin
                merge_hit = 1'b1;
                merge_sel = PTR_W'(i);
            end
        end
    end

    assign do_merge = addrgen_btb_update_vld && !btb_upd_flush && merge_hit;
    assign do_push  = addrgen_btb_update_vld && !btb_upd_flush && !merge_hit &&
                      (!ubuf_full || pop);
    assign ifu_hpcp_btb_upd_drop = addrgen_btb_update_vld && !btb_upd_flush && !merge_hit &&
                                   ubuf_full && !pop;

    // Queue state: reset, then flush, then pop/merge/push.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            valid_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (btb_upd_flush) begin
            valid_q    <= '0;
            head_ptr_q <= tail_ptr_q;
        end else begin
            if (pop) begin
                valid_q[head_sel] <= 1'b0;
                head_ptr_q        <= head_ptr_q + (PTR_W + 1)'(1);
            end
            if (do_merge) begin
                tag_q[merge_sel] <= addrgen_btb_tag;
                tgt_q[merge_sel] <= addrgen_btb_target_pc;
            end
            // On full-with-pop the tail slot is the head slot; the set below wins.
            if (do_push) begin
                valid_q[tail_sel] <= 1'b1;
                idx_q[tail_sel]   <= addrgen_btb_index;
                tag_q[tail_sel]   <= addrgen_btb_tag;
                tgt_q[tail_sel]   <= addrgen_btb_target_pc;
                tail_ptr_q        <= tail_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

endmodule
